// File: rtl/apple1_pkg.sv
// Shared constants and helpers for the Apple-1 PIA-style keyboard/display port.
package apple1_pkg;

    // Register indices within the 0xD010-0xD013 window
    localparam logic [1:0] REG_KBD   = 2'd0;
    localparam logic [1:0] REG_KBDCR = 2'd1;
    localparam logic [1:0] REG_DSP   = 2'd2;
    localparam logic [1:0] REG_DSPCR = 2'd3;

    // Control-register bit positions (KBDCR and DSPCR share the layout)
    localparam int CR_OVF_CLR = 32'sd6;
    localparam int CR_FLUSH   = 32'sd0;

    // Ceiling log2, usable in parameter and port-width expressions
    function automatic int clog2(input int value);
        int r;
        r = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pia_fifo_port_sync_fifo.sv
// Single-clock FIFO with count-derived full/empty, flush and registered storage.
// Full/empty come from the count registered before the edge, so a push into a
// full FIFO is refused even when a pop happens in the same cycle.
module sync_fifo
    import apple1_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  W     = 7,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [AW:0]   count_nxt_s;

    // Qualify push/pop against the pre-edge occupancy and compute next count
    always_comb begin
        full        = (count_r == (AW+1)'(DEPTH));
        empty       = (count_r == '0);
        push_ok_s   = push & ~full;
        pop_ok_s    = pop & ~empty;
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = '0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_nxt_s = count_r + (AW+1)'(1);
                2'b01:   count_nxt_s = count_r - (AW+1)'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Storage array; cleared on reset so the head reads zero afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 32'sd0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok_s && !flush) begin
            mem[wr_ptr_r] <= din;
        end else begin
            mem[wr_ptr_r] <= mem[wr_ptr_r];
        end
    end

    // Pointers (wrap naturally modulo the power-of-two depth) and count
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;
    assign head  = mem[rd_ptr_r];

endmodule

// File: rtl/pia_fifo_port.sv
// Apple-1 keyboard/display PIA register block with a FIFO behind each direction,
// sticky overflow flags, occupancy counts and a real display busy bit.
module pia_fifo_port
    import apple1_pkg::*;
#(
    parameter int KBD_DEPTH = 4,
    parameter int DSP_DEPTH = 16,
    parameter int DATA_W    = 7
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              cpu_clken,
    input  logic              cs,
    input  logic [1:0]        addr,
    input  logic              we,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              kbd_valid,
    input  logic [DATA_W-1:0] kbd_data,
    output logic              kbd_ready,
    output logic              dsp_valid,
    output logic [DATA_W-1:0] dsp_data,
    input  logic              dsp_ready
);

    localparam int KAW = clog2(KBD_DEPTH);
    localparam int DAW = clog2(DSP_DEPTH);

    logic              rd_s;
    logic              wr_s;
    logic              kbd_pop_s;
    logic              kbd_flush_s;
    logic              kbd_clr_s;
    logic              kbd_ovf_set_s;
    logic              dsp_push_s;
    logic              dsp_flush_s;
    logic              dsp_clr_s;
    logic              dsp_ovf_set_s;
    logic              kbd_full_s;
    logic              kbd_empty_s;
    logic [KAW:0]      kbd_count_s;
    logic [DATA_W-1:0] kbd_head_s;
    logic              dsp_full_s;
    logic              dsp_empty_s;
    logic [DAW:0]      dsp_count_s;
    logic              kbd_ovf_r;
    logic              dsp_ovf_r;

    // Bus decode: every side effect is qualified by cpu_clken so a held cs never acts twice
    always_comb begin
        rd_s          = cs & cpu_clken & ~we;
        wr_s          = cs & cpu_clken & we;
        kbd_pop_s     = rd_s & (addr == REG_KBD);
        kbd_flush_s   = wr_s & (addr == REG_KBDCR) & din[CR_FLUSH];
        kbd_clr_s     = wr_s & (addr == REG_KBDCR) & din[CR_OVF_CLR];
        dsp_push_s    = wr_s & (addr == REG_DSP);
        dsp_flush_s   = wr_s & (addr == REG_DSPCR) & din[CR_FLUSH];
        dsp_clr_s     = wr_s & (addr == REG_DSPCR) & din[CR_OVF_CLR];
        // A push lost to a full FIFO counts as overflow unless a flush discards it anyway
        kbd_ovf_set_s = kbd_valid & kbd_full_s & ~kbd_flush_s;
        dsp_ovf_set_s = dsp_push_s & dsp_full_s & ~dsp_flush_s;
    end

    sync_fifo #(
        .DEPTH (KBD_DEPTH),
        .W     (DATA_W)
    ) u_kbd_fifo (
        .clk   (sys_clock),
        .reset (reset),
        .push  (kbd_valid),
        .pop   (kbd_pop_s),
        .flush (kbd_flush_s),
        .din   (kbd_data),
        .full  (kbd_full_s),
        .empty (kbd_empty_s),
        .count (kbd_count_s),
        .head  (kbd_head_s)
    );

    sync_fifo #(
        .DEPTH (DSP_DEPTH),
        .W     (DATA_W)
    ) u_dsp_fifo (
        .clk   (sys_clock),
        .reset (reset),
        .push  (dsp_push_s),
        .pop   (dsp_ready),
        .flush (dsp_flush_s),
        .din   (din[DATA_W-1:0]),
        .full  (dsp_full_s),
        .empty (dsp_empty_s),
        .count (dsp_count_s),
        .head  (dsp_data)
    );

    // Sticky overflow flags: a set in the same cycle as a clear wins
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            kbd_ovf_r <= 1'b0;
            dsp_ovf_r <= 1'b0;
        end else begin
            if (kbd_ovf_set_s) begin
                kbd_ovf_r <= 1'b1;
            end else if (kbd_clr_s) begin
                kbd_ovf_r <= 1'b0;
            end else begin
                kbd_ovf_r <= kbd_ovf_r;
            end
            if (dsp_ovf_set_s) begin
                dsp_ovf_r <= 1'b1;
            end else if (dsp_clr_s) begin
                dsp_ovf_r <= 1'b0;
            end else begin
                dsp_ovf_r <= dsp_ovf_r;
            end
        end
    end

    // Read mux; the DSP read exposes only the busy (full) bit polled by the monitor
    always_comb begin
        dout = 8'h00;
        case (addr)
            REG_KBD:   dout = {~kbd_empty_s, 7'(kbd_head_s)};
            REG_KBDCR: dout = {~kbd_empty_s, kbd_ovf_r, 6'(kbd_count_s)};
            REG_DSP:   dout = {dsp_full_s, 7'h00};
            REG_DSPCR: dout = {dsp_full_s, dsp_ovf_r, 6'(dsp_count_s)};
            default:   dout = 8'h00;
        endcase
    end

    assign kbd_ready = ~kbd_full_s;
    assign dsp_valid = ~dsp_empty_s;

endmodule

// File: tb/tb_pia_fifo_port.sv
// Directed plus randomized bench for pia_fifo_port against a queue-based model.
module tb_pia_fifo_port;

    localparam int KD = 4;
    localparam int DD = 16;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       cpu_clken;
    logic       cs;
    logic [1:0] addr;
    logic       we;
    logic [7:0] din;
    logic [7:0] dout;
    logic       kbd_valid;
    logic [6:0] kbd_data;
    logic       kbd_ready;
    logic       dsp_valid;
    logic [6:0] dsp_data;
    logic       dsp_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [6:0] kq[$];
    logic [6:0] dq[$];
    bit         kovf, dovf;
    bit         k_fresh, d_fresh;

    pia_fifo_port #(.KBD_DEPTH(KD), .DSP_DEPTH(DD), .DATA_W(7)) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .cpu_clken (cpu_clken),
        .cs        (cs),
        .addr      (addr),
        .we        (we),
        .din       (din),
        .dout      (dout),
        .kbd_valid (kbd_valid),
        .kbd_data  (kbd_data),
        .kbd_ready (kbd_ready),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic c, input logic ck, input logic [1:0] a,
                       input logic w, input logic [7:0] d);
        cs = c; cpu_clken = ck; addr = a; we = w; din = d;
    endtask

    task automatic check_model();
        logic [7:0] e, m;
        m = 8'hFF;
        case (addr)
            2'd0: begin
                if (kq.size() != 0) e = {1'b1, kq[0]};
                else begin e = 8'h00; m = k_fresh ? 8'hFF : 8'h80; end
            end
            2'd1:    e = {kq.size() != 0, kovf, 6'(kq.size())};
            2'd2:    e = {dq.size() == DD, 7'h00};
            default: e = {dq.size() == DD, dovf, 6'(dq.size())};
        endcase
        chk("dout_model", dout & m, e & m);
        chk("kbd_ready_model", {7'h00, kbd_ready}, {7'h00, kq.size() != KD});
        chk("dsp_valid_model", {7'h00, dsp_valid}, {7'h00, dq.size() != 0});
        if (dq.size() != 0) chk("dsp_data_model", {1'b0, dsp_data}, {1'b0, dq[0]});
        else if (d_fresh) chk("dsp_data_reset", {1'b0, dsp_data}, 8'h00);
    endtask

    task automatic model_update();
        bit rd, wr, kfull, kempty, dfull, dempty, kfl, kcl, dfl, dcl;
        if (reset) begin
            kq.delete(); dq.delete();
            kovf = 1'b0; dovf = 1'b0; k_fresh = 1'b1; d_fresh = 1'b1;
            return;
        end
        rd     = cs && cpu_clken && !we;
        wr     = cs && cpu_clken && we;
        kfull  = kq.size() == KD;
        kempty = kq.size() == 0;
        dfull  = dq.size() == DD;
        dempty = dq.size() == 0;
        kfl    = wr && addr == 2'd1 && din[0];
        kcl    = wr && addr == 2'd1 && din[6];
        dfl    = wr && addr == 2'd3 && din[0];
        dcl    = wr && addr == 2'd3 && din[6];
        if (kbd_valid && kfull && !kfl) kovf = 1'b1;
        else if (kcl) kovf = 1'b0;
        if (wr && addr == 2'd2 && dfull && !dfl) dovf = 1'b1;
        else if (dcl) dovf = 1'b0;
        if (kbd_valid) k_fresh = 1'b0;
        if (wr && addr == 2'd2) d_fresh = 1'b0;
        if (kfl) kq.delete();
        else begin
            if (rd && addr == 2'd0 && !kempty) void'(kq.pop_front());
            if (kbd_valid && !kfull) kq.push_back(kbd_data);
        end
        if (dfl) dq.delete();
        else begin
            if (dsp_ready && !dempty) void'(dq.pop_front());
            if (wr && addr == 2'd2 && !dfull) dq.push_back(din[6:0]);
        end
    endtask

    task automatic step();
        #1;
        check_model();
        model_update();
        @(posedge sys_clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; kbd_valid = 1'b0; kbd_data = 7'h00; dsp_ready = 1'b0;
        bus(1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        model_update();
        @(posedge sys_clock); #1;
        @(posedge sys_clock); #1;
        reset = 1'b0;

        // Reset state
        bus(1'b1, 1'b1, 2'd1, 1'b0, 8'h00); #1; chk("rst_kbdcr", dout, 8'h00);
        chk("rst_kbd_ready", {7'h00, kbd_ready}, 8'h01);
        chk("rst_dsp_valid", {7'h00, dsp_valid}, 8'h00);
        chk("rst_dsp_data", {1'b0, dsp_data}, 8'h00);
        step();
        bus(1'b1, 1'b1, 2'd0, 1'b0, 8'h00); #1; chk("rst_kbd", dout, 8'h00); step();
        bus(1'b1, 1'b1, 2'd2, 1'b0, 8'h00); #1; chk("rst_dsp", dout, 8'h00); step();

        // Keyboard push then CPU read pop
        bus(1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        kbd_valid = 1'b1; kbd_data = 7'h41; step(); kbd_valid = 1'b0;
        bus(1'b1, 1'b1, 2'd0, 1'b0, 8'h00); #1; chk("kbd_read_A", dout, 8'hC1); step();
        bus(1'b1, 1'b1, 2'd1, 1'b0, 8'h00); #1; chk("kbdcr_after_pop", dout, 8'h00); step();

        // Fill display FIFO, overflow it, clear the flag
        for (int i = 0; i < DD; i++) begin
            bus(1'b1, 1'b1, 2'd2, 1'b1, {i[0], 7'h30 + 7'(i)}); step();
        end
        bus(1'b1, 1'b1, 2'd2, 1'b0, 8'h00); #1; chk("dsp_busy", dout, 8'h80); step();
        bus(1'b1, 1'b1, 2'd2, 1'b1, 8'h7A); step();
        bus(1'b1, 1'b1, 2'd3, 1'b0, 8'h00); #1; chk("dspcr_ovf", dout, 8'hD0); step();
        bus(1'b1, 1'b1, 2'd3, 1'b1, 8'h40); step();
        bus(1'b1, 1'b1, 2'd3, 1'b0, 8'h00); #1; chk("dspcr_clr", dout, 8'h90); step();

        // Drain in order, one per clock
        bus(1'b0, 1'b0, 2'd3, 1'b0, 8'h00); dsp_ready = 1'b1;
        for (int i = 0; i < DD; i++) begin
            #1;
            chk("drain_valid", {7'h00, dsp_valid}, 8'h01);
            chk("drain_data", {1'b0, dsp_data}, 8'h30 + 8'(i));
            step();
        end
        #1; chk("drain_empty", {7'h00, dsp_valid}, 8'h00);
        dsp_ready = 1'b0;

        // Held KBD read, cpu_clken high on one cycle only
        kbd_valid = 1'b1; kbd_data = 7'h11; step();
        kbd_data = 7'h12; step(); kbd_valid = 1'b0;
        bus(1'b1, 1'b0, 2'd0, 1'b0, 8'h00); step();
        bus(1'b1, 1'b1, 2'd0, 1'b0, 8'h00); step();
        bus(1'b1, 1'b0, 2'd0, 1'b0, 8'h00); #1; chk("held_kbd_head", dout, 8'h92); step();
        bus(1'b1, 1'b1, 2'd1, 1'b0, 8'h00); #1; chk("held_one_pop", dout, 8'h81); step();

        // Keyboard full: push + flush discards without overflow
        bus(1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        kbd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin kbd_data = 7'h20 + 7'(i); step(); end
        kbd_data = 7'h55; bus(1'b1, 1'b1, 2'd1, 1'b1, 8'h01); step();
        kbd_valid = 1'b0;
        bus(1'b1, 1'b0, 2'd1, 1'b0, 8'h00); #1; chk("kbd_flush_no_ovf", dout, 8'h00); step();

        // Keyboard full: overflow set beats clear
        kbd_valid = 1'b1;
        for (int i = 0; i < KD; i++) begin kbd_data = 7'h60 + 7'(i); step(); end
        bus(1'b1, 1'b1, 2'd1, 1'b1, 8'h40); step();
        kbd_valid = 1'b0;
        bus(1'b1, 1'b1, 2'd1, 1'b0, 8'h00); #1; chk("kbd_set_wins", dout, 8'hC4); step();

        // Display full + overflow, then flush with a concurrent pop
        for (int i = 0; i <= DD; i++) begin
            bus(1'b1, 1'b1, 2'd2, 1'b1, 8'h40 + 8'(i)); step();
        end
        dsp_ready = 1'b1; bus(1'b1, 1'b1, 2'd3, 1'b1, 8'h01); step();
        dsp_ready = 1'b0;
        bus(1'b1, 1'b1, 2'd3, 1'b0, 8'h00); #1; chk("dsp_flush_pop", dout, 8'h40); step();

        // Reset with data queued
        bus(1'b1, 1'b1, 2'd2, 1'b1, 8'h33); step(); step();
        bus(1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
        reset = 1'b1; step(); reset = 1'b0;
        bus(1'b1, 1'b0, 2'd1, 1'b0, 8'h00); #1; chk("mid_rst_kbdcr", dout, 8'h00);
        bus(1'b1, 1'b0, 2'd3, 1'b0, 8'h00); #1; chk("mid_rst_dspcr", dout, 8'h00);
        bus(1'b1, 1'b0, 2'd0, 1'b0, 8'h00); #1; chk("mid_rst_kbd", dout, 8'h00);
        chk("mid_rst_kbd_ready", {7'h00, kbd_ready}, 8'h01);
        chk("mid_rst_dsp_valid", {7'h00, dsp_valid}, 8'h00);
        chk("mid_rst_dsp_data", {1'b0, dsp_data}, 8'h00);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            cs        = 1'($urandom_range(0, 1));
            cpu_clken = ($urandom_range(0, 3) != 0);
            addr      = 2'($urandom_range(0, 3));
            we        = 1'($urandom_range(0, 1));
            din       = 8'($urandom);
            if (addr[0] && $urandom_range(0, 3) != 0) din[0] = 1'b0;
            kbd_valid = 1'($urandom_range(0, 1));
            kbd_data  = 7'($urandom);
            dsp_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pia_fifo_port.md
# pia_fifo_port

Parametrised successor to the fixed Apple-1 keyboard/display port pair at 0xD010–0xD013. It presents the four PIA-style registers (KBD, KBDCR, DSP, DSPCR) to the 6502 bus and places a FIFO behind each direction. It provides the following behaviour the current top level lacks:
- a real display busy flag;
- buffered keystrokes;
- sticky overflow flags;
- FIFO occupancy counts.

It sits between the address decoder and the keyboard and display engines, and replaces the hard-wired `display_dout = 0`.

## Interface
Parameters:
- `KBD_DEPTH`, default 4: keyboard FIFO entries; power of two, 2..32.
- `DSP_DEPTH`, default 16: display FIFO entries; power of two, 2..32.
- `DATA_W`, default 7: character width stored in each FIFO; 1..7.

Ports (one clock domain; `reset` is synchronous, active-high):
- `sys_clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous active-high reset.
- `cpu_clken` in 1: CPU clock enable; bus accesses are qualified by it.
- `cs` in 1: select for the 0xD010–0xD013 window.
- `addr` in 2: register select; 0 = KBD, 1 = KBDCR, 2 = DSP, 3 = DSPCR.
- `we` in 1: CPU write strobe.
- `din` in 8: CPU write data.
- `dout` out 8: CPU read data; combinational from the current `addr` and state.
- `kbd_valid` in 1: keyboard engine offers a character.
- `kbd_data` in DATA_W: offered character.
- `kbd_ready` out 1: keyboard FIFO not full.
- `dsp_valid` out 1: display FIFO not empty.
- `dsp_data` out DATA_W: head of the display FIFO.
- `dsp_ready` in 1: display engine consumes the head.

## Operation
Access qualifiers:
- `acc = cs & cpu_clken`
- `rd = acc & ~we`
- `wr = acc & we`

Register 0, KBD:
- Read: `dout = {~kbd_empty, zero-extend(kbd_head)}`.
- A read with the FIFO non-empty pops one entry.
- A read with the FIFO empty returns the stale head with bit7 = 0 and pops nothing.
- Writes are ignored.

Register 1, KBDCR:
- Read: `dout = {~kbd_empty, kbd_ovf, kbd_count[5:0]}`.
- A write with `din[6]=1` clears `kbd_ovf`.
- A write with `din[0]=1` flushes the keyboard FIFO.

Register 2, DSP:
- Write pushes `din[DATA_W-1:0]`; bit7 of `din` is discarded.
- A write while the FIFO is full is dropped and sets `dsp_ovf`.
- Read: `dout = {dsp_full, 7'b0}`. This is the busy bit that Woz Monitor polls.

Register 3, DSPCR:
- Read: `dout = {dsp_full, dsp_ovf, dsp_count[5:0]}`.
- Writes use the same bit6 and bit0 semantics as KBDCR, applied to the display side.

Keyboard push and display pop:
- Keyboard push happens when `kbd_valid & kbd_ready`.
- If `kbd_valid` is asserted while the FIFO is full, `kbd_ovf` is set and the data is lost.
- Display pop happens when `dsp_valid & dsp_ready`.

Counts are `DEPTH_W+1` bits wide, with `DEPTH_W = log2(DEPTH)`. Pointers wrap modulo DEPTH. Full and empty are derived from the count.

## Timing
- Reset values: both FIFOs empty, pointers 0, counts 0, `kbd_ovf = 0`, `dsp_ovf = 0`, `kbd_ready = 1`, `dsp_valid = 0`, `dsp_data = 0`.
- On the `dout` path after reset, the KBD head reads 0.
- Push to visible: a character pushed at edge N shows on `dsp_valid`/`dsp_data`, and in the KBD/KBDCR bit7, from N+1.
- No combinational path from the same cycle's push exists.
- `kbd_ready` and `dsp_full` are decided from the count registered before the edge:
  - A push into a full FIFO is rejected even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- A simultaneous push and pop on an empty FIFO: only the push takes effect.
- A flush in the same cycle as a push or pop: the flush wins. The FIFO is empty afterwards and the push is discarded without setting overflow.
- Overflow set and clear in the same cycle: set wins.
- Read-pop side effects apply only on cycles where `cpu_clken = 1`. A held `cs` with `cpu_clken = 0` never pops twice.
- Reset asserted mid-operation discards all FIFO contents on that edge.

## Structure
- Package `apple1_pkg` holds:
  - the register index constants `REG_KBD`, `REG_KBDCR`, `REG_DSP`, `REG_DSPCR`;
  - the control-bit positions `CR_OVF_CLR = 6` and `CR_FLUSH = 0`;
  - a `clog2` function.
- One sub-module, `sync_fifo` (parameters DEPTH and W). It has push, pop, flush, full, empty, count and head ports, plus a registered storage array. It is instantiated once per direction.
- The top block contains the register decode, the `dout` mux and the sticky flags.

## Test plan
- Reset, then read KBDCR -> 0x00. Read DSP -> 0x00. Check `kbd_ready = 1` and `dsp_valid = 0`.
- Push 'A' (0x41) on the keyboard side, then read KBD with `cpu_clken = 1` -> 0xC1. The next read of KBDCR -> 0x00.
- With DSP_DEPTH = 16 and `dsp_ready = 0`, write 17 characters:
  - after the 16th write, DSP reads 0x80;
  - the 17th write is dropped and DSPCR reads 0xD0;
  - writing 0x40 to DSPCR -> DSPCR reads 0x90.
- Drain with `dsp_ready = 1` -> `dsp_data` presents the 16 characters in order, one per clock, then `dsp_valid = 0`.
- Hold the KBD read for 3 cycles with `cpu_clken` high on only 1 of them, and 2 keys queued -> exactly one pop; KBDCR count = 1.
- FIFO full with a simultaneous push, pop and DSPCR flush -> count = 0 and `dsp_ovf` unchanged. Then assert `reset` with data queued -> all state returns to the reset values on the next edge.
